// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, debug and instruction-memory signals around the arbiter.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface imem_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [31:0]      if_rdata;
  logic             if_err;
  logic             dbg_req;
  logic [31:0]      dbg_addr;
  logic             dbg_gnt;
  logic             dbg_rvalid;
  logic [31:0]      dbg_rdata;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data;
  logic [CNT_W-1:0] if_gnt_cnt;
  logic [CNT_W-1:0] dbg_gnt_cnt;

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, mem_data,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr, if_gnt_cnt, dbg_gnt_cnt
  );

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, mem_data,
    output if_gnt, if_rvalid, if_rdata, if_err,
           dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr, if_gnt_cnt, dbg_gnt_cnt
  );
endinterface

// File: rtl/imem_arbiter.sv
// Fixed-priority share of the instruction-memory read port between fetch and debug,
// with a starvation escape for debug and a registered one-cycle read response.
module imem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic             force_dbg;
  logic             if_gnt;
  logic             dbg_gnt;
  logic [31:0]      mem_addr;
  logic [31:0]      addr_q;
  logic [3:0]       starve_cnt;
  logic             if_vld_q;
  logic             if_err_q;
  logic [31:0]      if_data_q;
  logic             dbg_vld_q;
  logic [31:0]      dbg_data_q;
  logic [CNT_W-1:0] if_cnt;
  logic [CNT_W-1:0] dbg_cnt;

  always_comb begin
    force_dbg = bus.dbg_req & (starve_cnt == STARVE_LIM);
    if_gnt    = bus.if_req & ~force_dbg & ~reset;
    dbg_gnt   = bus.dbg_req & ~if_gnt & ~reset;
    mem_addr  = addr_q;
    if (if_gnt)       mem_addr = {bus.if_addr[31:2], 2'b00};
    else if (dbg_gnt) mem_addr = {bus.dbg_addr[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      starve_cnt <= '0;
      if_vld_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_data_q  <= '0;
      dbg_vld_q  <= 1'b0;
      dbg_data_q <= '0;
      if_cnt     <= '0;
      dbg_cnt    <= '0;
    end else begin
      if (if_gnt | dbg_gnt) addr_q <= mem_addr;
      if_vld_q  <= if_gnt;
      if_err_q  <= if_gnt & (|bus.if_addr[1:0]);
      dbg_vld_q <= dbg_gnt;
      if (if_gnt)  if_data_q  <= bus.mem_data;
      if (dbg_gnt) dbg_data_q <= bus.mem_data;
      if (if_gnt)  if_cnt  <= if_cnt + 1'b1;
      if (dbg_gnt) dbg_cnt <= dbg_cnt + 1'b1;
      // Counts only cycles where debug keeps asking and loses.
      if (!bus.dbg_req || dbg_gnt)    starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // A response launched just before reset must not be seen while reset is held.
  assign bus.if_gnt      = if_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.mem_addr    = mem_addr;
  assign bus.if_rvalid   = if_vld_q & ~reset;
  assign bus.if_err      = if_err_q & ~reset;
  assign bus.if_rdata    = if_data_q;
  assign bus.dbg_rvalid  = dbg_vld_q & ~reset;
  assign bus.dbg_rdata   = dbg_data_q;
  assign bus.if_gnt_cnt  = if_cnt;
  assign bus.dbg_gnt_cnt = dbg_cnt;
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter with a queue-based scoreboard.
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_arbiter_if #(.CNT_W(16)) bus ();
  imem_arbiter_if #(.CNT_W(4))  bus4 ();

  imem_arbiter #(.STARVE_MAX(4), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  imem_arbiter #(.STARVE_MAX(4), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic [31:0] mem [0:255];
  assign bus.mem_data   = mem[bus.mem_addr[9:2]];
  assign bus4.mem_data  = mem[bus4.mem_addr[9:2]];
  assign bus4.if_req    = bus.if_req;
  assign bus4.if_addr   = bus.if_addr;
  assign bus4.dbg_req   = bus.dbg_req;
  assign bus4.dbg_addr  = bus.dbg_addr;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        qi[$];
  exp_t        qd[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          denied = 0;
  logic [15:0] m_if_cnt = '0;
  logic [15:0] m_dbg_cnt = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dbg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: debug wins once it has lost four cycles in a row, else fetch wins.
  always @(negedge clk) begin
    logic        w_if, w_dbg;
    logic [31:0] a;
    if (reset) begin
      denied = 0; m_if_cnt = '0; m_dbg_cnt = '0; m_addr = '0;
      qi.delete(); qd.delete();
      chk("gnt_in_reset", 32'({bus.if_gnt, bus.dbg_gnt}), 32'd0);
    end else begin
      w_dbg = bus.dbg_req && (denied >= 4);
      w_if  = bus.if_req && !w_dbg;
      w_dbg = bus.dbg_req && !w_if;
      chk("if_gnt", 32'(bus.if_gnt), 32'(w_if));
      chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(w_dbg));
      chk("if_gnt_cnt", 32'(bus.if_gnt_cnt), 32'(m_if_cnt));
      chk("dbg_gnt_cnt", 32'(bus.dbg_gnt_cnt), 32'(m_dbg_cnt));
      chk("if_gnt_cnt4", 32'(bus4.if_gnt_cnt), 32'(m_if_cnt % 16));
      if (w_if) begin
        a = bus.if_addr & ~32'd3;
        qi.push_back('{mem[a[9:2]], (bus.if_addr % 4) != 0, cyc + 1});
        m_if_cnt++; m_addr = a;
      end else if (w_dbg) begin
        a = bus.dbg_addr & ~32'd3;
        qd.push_back('{mem[a[9:2]], 1'b0, cyc + 1});
        m_dbg_cnt++; m_addr = a;
      end
      chk("mem_addr", bus.mem_addr, m_addr);
      if (bus.dbg_req && !w_dbg) denied++; else denied = 0;
    end
  end

  // Response monitor: pops the scoreboard whenever a response channel fires.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_if = '0; last_dbg = '0;
      chk("rvalid_in_reset", 32'({bus.if_rvalid, bus.dbg_rvalid}), 32'd0);
    end else begin
      if (bus.if_rvalid) begin
        if (qi.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = qi.pop_front();
          chk("if_rdata", bus.if_rdata, e.data);
          chk("if_err", 32'(bus.if_err), 32'(e.err));
          chk("if_latency", 32'(cyc), 32'(e.due));
          last_if = e.data;
        end
      end else begin
        if (qi.size() != 0 && qi[0].due <= cyc) begin
          chk("if_missing_rvalid", 32'd0, 32'd1);
          void'(qi.pop_front());
        end
        chk("if_rdata_hold", bus.if_rdata, last_if);
        chk("if_err_idle", 32'(bus.if_err), 32'd0);
      end
      if (bus.dbg_rvalid) begin
        if (qd.size() == 0) chk("dbg_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = qd.pop_front();
          chk("dbg_rdata", bus.dbg_rdata, e.data);
          chk("dbg_latency", 32'(cyc), 32'(e.due));
          last_dbg = e.data;
        end
      end else begin
        if (qd.size() != 0 && qd[0].due <= cyc) begin
          chk("dbg_missing_rvalid", 32'd0, 32'd1);
          void'(qd.pop_front());
        end
        chk("dbg_rdata_hold", bus.dbg_rdata, last_dbg);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0; bus.dbg_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093; mem[2] = 32'h0020_0113;
    mem[4] = 32'hDEAD_BEEF;
    reset = 1'b1; idle(); bus.if_addr = '0; bus.dbg_addr = '0;
    step(); step(); reset = 1'b0;

    // Fetch only, three consecutive words.
    bus.if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.if_addr = 32'(i * 4); step(); end
    idle(); step();
    @(negedge clk); chk("fetch_only_cnt", 32'(bus.if_gnt_cnt), 32'd3);
    step();

    // Debug only at 0x10.
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h10;
    @(negedge clk); chk("dbg_mem_addr", bus.mem_addr, 32'h10);
    step(); idle();
    @(negedge clk);
    chk("dbg_rdata_beef", bus.dbg_rdata, 32'hDEAD_BEEF);
    chk("if_rdata_kept", bus.if_rdata, 32'h0020_0113);
    step();

    // Starvation: both requesting for ten cycles.
    bus.if_req = 1'b1; bus.dbg_req = 1'b1; bus.if_addr = 32'h20; bus.dbg_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("starve_pattern", 32'(bus.dbg_gnt), 32'((i == 4) || (i == 9)));
      step();
    end
    idle(); step();

    // Misaligned fetch then aligned fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h06;
    @(negedge clk); chk("misalign_mem_addr", bus.mem_addr, 32'h04);
    step(); bus.if_addr = 32'h08;
    @(negedge clk); chk("misalign_err", 32'(bus.if_err), 32'd1);
    step(); idle();
    @(negedge clk); chk("aligned_err", 32'(bus.if_err), 32'd0);
    step();

    // Reset right after a fetch grant; response must be dropped.
    bus.if_req = 1'b1; bus.if_addr = 32'h08;
    step(); idle(); reset = 1'b1;
    step();
    @(negedge clk);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_if_cnt", 32'(bus.if_gnt_cnt), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    step(); reset = 1'b0;

    // Seventeen fetch grants wrap the 4-bit counter to one.
    bus.if_req = 1'b1;
    for (int i = 0; i < 17; i++) begin bus.if_addr = 32'($urandom_range(0, 255) * 4); step(); end
    idle();
    @(negedge clk); chk("wrap_cnt4", 32'(bus4.if_gnt_cnt), 32'd1);
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      bus.if_req   = ($urandom_range(0, 3) != 0);
      bus.dbg_req  = ($urandom_range(0, 2) != 0);
      bus.if_addr  = 32'($urandom_range(0, 1023));
      bus.dbg_addr = 32'($urandom_range(0, 1023));
      reset        = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; idle();
    repeat (3) step();
    @(negedge clk); chk("drain", 32'(qi.size() + qd.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
